// File: rtl/data_ram_ctrl_pkg.sv
// Shared widths, FSM encodings and helpers for the data RAM controller.
// Imported by data_ram_ctrl and its local byte-lane RAM.
package data_ram_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [1:0] RAMC_IDLE = 2'd0;
  localparam logic [1:0] RAMC_BUSY = 2'd1;
  localparam logic [1:0] RAMC_DONE = 2'd2;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/data_ram_ctrl_byte_en_ram.sv
// Single-port 2^AW x 32 RAM with per-byte write enables and a registered read.
// Each lane is its own array so every lane maps cleanly onto block RAM.
module byte_en_ram
  import data_ram_ctrl_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic [SEL_W-1:0]  we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      // Read port only updates on a read so the output holds between reads.
      always_ff @(posedge clk) begin
        if (we[gi]) lane_mem[addr] <= wdata[8*gi +: 8];
        if (re)     lane_q_reg     <= lane_mem[addr];
      end

      assign rdata[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/data_ram_ctrl.sv
// Core data-RAM responder: local BRAM without stall, everything else over a req/ack bus.
// Define DATA_RAM_CTRL_CYCLE_CNT_EN to map a free-running cycle counter at CNT_ADDR.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int unsigned       LOCAL_AW    = 12,
  parameter int unsigned       EXT_TIMEOUT = 255,
  parameter logic [ADDR_W-1:0] CNT_ADDR    = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [SEL_W-1:0]  ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              stall,
  output logic              ext_req,
  output logic [SEL_W-1:0]  ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_ack,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              bus_err
);

  localparam int TW = (EXT_TIMEOUT < 2) ? 1 : $clog2(EXT_TIMEOUT + 1);

  logic [1:0]        state_reg;
  logic              ext_req_reg;
  logic [SEL_W-1:0]  ext_we_reg;
  logic [ADDR_W-1:0] ext_addr_reg;
  logic [DATA_W-1:0] ext_wdata_reg;
  logic              bus_err_reg;
  logic [TW-1:0]     tcnt_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rd_local_reg;
  logic [DATA_W-1:0] bram_q;
  logic [DATA_W-1:0] cnt_val;
  logic              local_hit, local_sel, cnt_hit, ext_hit, is_read;
  logic              idle_access, timeout_hit, local_re;
  logic [SEL_W-1:0]  local_we;
  logic              unused_addr_bits;

`ifdef DATA_RAM_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
  logic [31:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_reg + 32'd1;
  end

  assign cnt_val = cnt_reg;
`else
  localparam bit CNT_EN = 1'b0;
  assign cnt_val = '0;
`endif

  assign unused_addr_bits = &{1'b0, ram_addr[1:0]};

  assign local_hit   = (ram_addr[ADDR_W-1:LOCAL_AW+2] == '0);
  assign cnt_hit     = CNT_EN && (ram_addr[ADDR_W-1:2] == CNT_ADDR[ADDR_W-1:2]);
  assign local_sel   = local_hit && !cnt_hit;
  assign ext_hit     = ram_en && !local_hit && !cnt_hit;
  assign is_read     = (ram_write_en == '0);
  assign idle_access = !rst && ram_en && (state_reg == RAMC_IDLE);
  assign timeout_hit = (EXT_TIMEOUT != 0) && (32'(tcnt_reg) == EXT_TIMEOUT - 1);

  assign stall = !rst && (((state_reg == RAMC_IDLE) && ext_hit) || (state_reg == RAMC_BUSY));

  // Local accesses only happen in IDLE; in DONE the core still shows the finished external access.
  assign local_we = (idle_access && local_sel) ? ram_write_en : '0;
  assign local_re = idle_access && local_sel && is_read;

  byte_en_ram #(
    .AW(LOCAL_AW)
  ) u_ram (
    .clk  (clk),
    .we   (local_we),
    .re   (local_re),
    .addr (ram_addr[LOCAL_AW+1:2]),
    .wdata(ram_write_data),
    .rdata(bram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RAMC_IDLE;
      ext_req_reg   <= 1'b0;
      ext_we_reg    <= '0;
      ext_addr_reg  <= '0;
      ext_wdata_reg <= '0;
      bus_err_reg   <= 1'b0;
      tcnt_reg      <= '0;
      rdata_reg     <= '0;
      rd_local_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RAMC_IDLE: begin
          if (ext_hit) begin
            ext_we_reg    <= ram_write_en;
            ext_addr_reg  <= word_align(ram_addr);
            ext_wdata_reg <= ram_write_data;
            ext_req_reg   <= 1'b1;
            tcnt_reg      <= '0;
            state_reg     <= RAMC_BUSY;
          end else if (ram_en && is_read) begin
            if (cnt_hit) begin
              rdata_reg    <= cnt_val;
              rd_local_reg <= 1'b0;
            end else begin
              rd_local_reg <= 1'b1;
            end
          end
        end
        RAMC_BUSY: begin
          tcnt_reg <= tcnt_reg + TW'(1);
          // An ack arriving in the timeout cycle still counts as a normal completion.
          if (ext_ack) begin
            ext_req_reg <= 1'b0;
            if (ext_we_reg == '0) begin
              rdata_reg    <= ext_rdata;
              rd_local_reg <= 1'b0;
            end
            state_reg <= RAMC_DONE;
          end else if (timeout_hit) begin
            ext_req_reg <= 1'b0;
            bus_err_reg <= 1'b1;
            if (ext_we_reg == '0) begin
              rdata_reg    <= '0;
              rd_local_reg <= 1'b0;
            end
            state_reg <= RAMC_DONE;
          end
        end
        RAMC_DONE: state_reg <= RAMC_IDLE;
        default:   state_reg <= RAMC_IDLE;
      endcase
    end
  end

  assign ram_read_data = rd_local_reg ? bram_q : rdata_reg;
  assign ext_req       = ext_req_reg;
  assign ext_we        = ext_we_reg;
  assign ext_addr      = ext_addr_reg;
  assign ext_wdata     = ext_wdata_reg;
  assign bus_err       = bus_err_reg;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl; expected read data flows through a scoreboard queue.
// Also covers the cycle counter when DATA_RAM_CTRL_CYCLE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        stall;
  logic        ext_req;
  logic [3:0]  ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] model_cnt;

  data_ram_ctrl #(
    .LOCAL_AW   (12),
    .EXT_TIMEOUT(4),
    .CNT_ADDR   (32'hFFFF_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_addr      (ram_addr),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data),
    .stall         (stall),
    .ext_req       (ext_req),
    .ext_we        (ext_we),
    .ext_addr      (ext_addr),
    .ext_wdata     (ext_wdata),
    .ext_ack       (ext_ack),
    .ext_rdata     (ext_rdata),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: zero after a reset edge, +1 on every other edge.
  always @(posedge clk) model_cnt <= rst ? 32'd0 : model_cnt + 32'd1;

  // Drives one core access and plays the external slave; the core holds the access while stalled.
  task automatic ext_access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                            input int ack_after, input logic [31:0] rd,
                            output int stall_n, output int req_n, output logic [3:0] cap_we,
                            output logic [31:0] cap_addr, output logic [31:0] cap_wdata);
    logic done;
    stall_n = 0; req_n = 0; cap_we = '0; cap_addr = '0; cap_wdata = '0;
    ram_en = 1'b1; ram_addr = a; ram_write_en = we; ram_write_data = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (ext_req) begin
        req_n++;
        if (req_n == 1) begin cap_we = ext_we; cap_addr = ext_addr; cap_wdata = ext_wdata; end
        if (req_n == ack_after) begin ext_ack = 1'b1; ext_rdata = rd; end
      end
      done = !stall && (stall_n > 0);
      @(posedge clk); #1;
      ext_ack = 1'b0;
      if (done || (stall_n == 0 && c > 2)) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_en = 1'b1; ram_addr = 32'h8000_0000; ram_write_en = 4'h0;
    ram_write_data = '0; ext_ack = 1'b0; ext_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (ram_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %08h expected 00000000", ram_read_data); end
    checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL reset_ext_req: got %0b expected 0", ext_req); end
    checks++; if ({ext_we, ext_addr, ext_wdata} !== 68'h0) begin errors++; $display("FAIL reset_ext_bus: got we=%h addr=%08h wdata=%08h expected zeros", ext_we, ext_addr, ext_wdata); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %0b expected 0", bus_err); end
    $display("reset: outputs sampled");
    @(posedge clk); #1;
    rst = 1'b0; ram_en = 1'b0;
  endtask

  task automatic test_local();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{32'h0000_0000, 32'h0000_0004, 32'h0000_3FFC};
    datas = '{32'h0102_0304, 32'hF0E1_D2C3, 32'h5A5A_A5A5};
    // Full-word write then a single-lane overwrite, then readback.
    ram_en = 1'b1; ram_addr = 32'h10; ram_write_en = 4'hF; ram_write_data = 32'hAABB_CCDD;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL local_wr_stall: got %0b expected 0", stall); end
    @(posedge clk); #1;
    ram_write_en = 4'b0010; ram_write_data = 32'h0000_1100;
    @(posedge clk); #1;
    ram_write_en = 4'h0; ram_write_data = '0;
    exp_q.push_back(32'hAABB_11DD);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL local_rd_stall: got %0b expected 0", stall); end
    @(posedge clk); #1;
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL local_lane_rd: got %08h expected %08h", ram_read_data, exp); end
    $display("local read 0x00000010 -> %08h", ram_read_data);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      ram_en = 1'b1; ram_addr = addrs[i]; ram_write_en = 4'hF; ram_write_data = datas[i];
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL local_wr_stall_%0d: got %0b expected 0", i, stall); end
      @(posedge clk); #1;
    end
    // Back-to-back reads: each result appears one cycle after its address.
    for (int i = 0; i < 3; i++) begin
      ram_en = 1'b1; ram_addr = addrs[i]; ram_write_en = 4'h0;
      exp_q.push_back(datas[i]);
      @(posedge clk);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL local_b2b_rd_%0d: got %08h expected %08h", i, ram_read_data, exp); end
      $display("local read 0x%08h -> %08h", addrs[i], ram_read_data);
    end
    ram_en = 1'b0;
    @(posedge clk); #1;
    // A later local write must not disturb the held read data.
    ram_en = 1'b1; ram_addr = 32'h0000_3FFC; ram_write_en = 4'hF; ram_write_data = 32'h1357_9BDF;
    @(posedge clk); #1;
    ram_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ram_read_data !== 32'h5A5A_A5A5) begin errors++; $display("FAIL local_hold: got %08h expected 5a5aa5a5", ram_read_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_ext_read();
    int s, r; logic [3:0] cw; logic [31:0] ca, cd;
    exp_q.push_back(32'h1234_5678);
    ext_access(32'h8000_0000, 4'h0, 32'h0, 3, 32'h1234_5678, s, r, cw, ca, cd);
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (s != 4) begin errors++; $display("FAIL ext_rd_stall_cycles: got %0d expected 4", s); end
    checks++; if (r != 3) begin errors++; $display("FAIL ext_rd_req_cycles: got %0d expected 3", r); end
    checks++; if (ca !== 32'h8000_0000) begin errors++; $display("FAIL ext_rd_addr: got %08h expected 80000000", ca); end
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL ext_rd_data: got %08h expected %08h", ram_read_data, exp); end
    $display("ext read 0x80000000 -> %08h (stall %0d, req %0d)", ram_read_data, s, r);
    // Boundary: first byte past the local region goes external.
    exp_q.push_back(32'h4000_0001);
    @(posedge clk); #1;
    ext_access(32'h0000_4000, 4'h0, 32'h0, 1, 32'h4000_0001, s, r, cw, ca, cd);
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (s != 2) begin errors++; $display("FAIL boundary_stall_cycles: got %0d expected 2", s); end
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL boundary_rd_data: got %08h expected %08h", ram_read_data, exp); end
    $display("ext read 0x00004000 -> %08h", ram_read_data);
    @(posedge clk); #1;
  endtask

  task automatic test_ext_write();
    int s, r; logic [3:0] cw; logic [31:0] ca, cd;
    exp_q.push_back(32'h4000_0001);
    ext_access(32'h8000_0006, 4'b1100, 32'hCAFE_BABE, 2, 32'hFFFF_FFFF, s, r, cw, ca, cd);
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (s != 3 || r != 2) begin errors++; $display("FAIL ext_wr_cycles: got stall=%0d req=%0d expected stall=3 req=2", s, r); end
    checks++; if (cw !== 4'b1100) begin errors++; $display("FAIL ext_wr_we: got %04b expected 1100", cw); end
    checks++; if (ca !== 32'h8000_0004) begin errors++; $display("FAIL ext_wr_addr: got %08h expected 80000004", ca); end
    checks++; if (cd !== 32'hCAFE_BABE) begin errors++; $display("FAIL ext_wr_wdata: got %08h expected cafebabe", cd); end
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL ext_wr_rdata_hold: got %08h expected %08h", ram_read_data, exp); end
    $display("ext write 0x80000006 we=%04b data=%08h", cw, cd);
    // Stray ack while idle must be ignored.
    ext_ack = 1'b1; ext_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    @(negedge clk);
    checks++; if (ram_read_data !== exp || stall !== 1'b0 || ext_req !== 1'b0) begin errors++; $display("FAIL idle_ack: got rdata=%08h stall=%0b req=%0b expected rdata=%08h stall=0 req=0", ram_read_data, stall, ext_req, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int s, r; logic [3:0] cw; logic [31:0] ca, cd;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL pre_timeout_bus_err: got %0b expected 0", bus_err); end
    exp_q.push_back(32'h0);
    ext_access(32'h8000_0100, 4'h0, 32'h0, 0, 32'h0, s, r, cw, ca, cd);
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (s != 5 || r != 4) begin errors++; $display("FAIL timeout_cycles: got stall=%0d req=%0d expected stall=5 req=4", s, r); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_bus_err: got %0b expected 1", bus_err); end
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL timeout_rdata: got %08h expected %08h", ram_read_data, exp); end
    $display("ext read 0x80000100 timed out -> %08h bus_err=%0b", ram_read_data, bus_err);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s1, r1, s2, r2; logic [3:0] cw; logic [31:0] ca, cd;
    exp_q.push_back(32'h1111_1111);
    exp_q.push_back(32'h2222_2222);
    ext_access(32'h8000_0010, 4'h0, 32'h0, 1, 32'h1111_1111, s1, r1, cw, ca, cd);
    exp = exp_q.pop_front();
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL b2b_first_data: got %08h expected %08h", ram_read_data, exp); end
    $display("ext read 0x80000010 -> %08h", ram_read_data);
    ext_access(32'h8000_0014, 4'h0, 32'h0, 2, 32'h2222_2222, s2, r2, cw, ca, cd);
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (s1 != 2 || r1 != 1) begin errors++; $display("FAIL b2b_first_cycles: got stall=%0d req=%0d expected stall=2 req=1", s1, r1); end
    checks++; if (s2 != 3 || r2 != 2) begin errors++; $display("FAIL b2b_second_cycles: got stall=%0d req=%0d expected stall=3 req=2", s2, r2); end
    checks++; if (ca !== 32'h8000_0014) begin errors++; $display("FAIL b2b_second_addr: got %08h expected 80000014", ca); end
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL b2b_second_data: got %08h expected %08h", ram_read_data, exp); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky: got %0b expected 1", bus_err); end
    $display("ext read 0x80000014 -> %08h", ram_read_data);
    @(posedge clk); #1;
  endtask

  task automatic test_rst_busy();
    ram_en = 1'b1; ram_addr = 32'h8000_0200; ram_write_en = 4'h0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL rst_busy_entry: got req=%0b expected 1", ext_req); end
    rst = 1'b1; ram_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ext_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_busy_drop: got req=%0b stall=%0b bus_err=%0b expected 0 0 0", ext_req, stall, bus_err); end
    ext_ack = 1'b1; ext_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    @(negedge clk);
    checks++; if (ram_read_data !== 32'h0 || ext_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got rdata=%08h req=%0b stall=%0b expected 00000000 0 0", ram_read_data, ext_req, stall); end
    $display("reset during busy: late ack ignored, rdata=%08h", ram_read_data);
    @(posedge clk); #1;
  endtask

  task automatic test_cycle_cnt();
`ifdef DATA_RAM_CTRL_CYCLE_CNT_EN
    logic [31:0] v1, v2;
    ram_en = 1'b1; ram_addr = 32'hFFFF_0000; ram_write_en = 4'h0;
    exp_q.push_back(model_cnt);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cnt_rd_stall: got %0b expected 0", stall); end
    @(posedge clk); #1;
    ram_en = 1'b0;
    @(negedge clk);
    v1 = ram_read_data;
    exp = exp_q.pop_front();
    checks++; if (v1 !== exp) begin errors++; $display("FAIL cnt_first: got %08h expected %08h", v1, exp); end
    $display("counter read -> %08h", v1);
    // Discarded write to the counter address, then the second read 5 cycles after the first.
    @(posedge clk); #1;
    ram_en = 1'b1; ram_write_en = 4'hF; ram_write_data = 32'h0;
    @(posedge clk); #1;
    ram_en = 1'b0; ram_write_en = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ram_en = 1'b1;
    exp_q.push_back(model_cnt);
    @(posedge clk); #1;
    ram_en = 1'b0;
    @(negedge clk);
    v2 = ram_read_data;
    exp = exp_q.pop_front();
    checks++; if (v2 !== exp) begin errors++; $display("FAIL cnt_second: got %08h expected %08h", v2, exp); end
    checks++; if (v2 - v1 !== 32'd5) begin errors++; $display("FAIL cnt_delta: got %0d expected 5", v2 - v1); end
    $display("counter read -> %08h", v2);
    @(posedge clk); #1;
`else
    int s, r; logic [3:0] cw; logic [31:0] ca, cd;
    exp_q.push_back(32'h7777_0000);
    ext_access(32'hFFFF_0000, 4'h0, 32'h0, 1, 32'h7777_0000, s, r, cw, ca, cd);
    ram_en = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (s != 2 || ca !== 32'hFFFF_0000) begin errors++; $display("FAIL cnt_addr_ext: got stall=%0d addr=%08h expected stall=2 addr=ffff0000", s, ca); end
    checks++; if (ram_read_data !== exp) begin errors++; $display("FAIL cnt_addr_ext_data: got %08h expected %08h", ram_read_data, exp); end
    $display("ext read 0xffff0000 -> %08h", ram_read_data);
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_local();
    test_ext_read();
    test_ext_write();
    test_timeout();
    test_back_to_back();
    test_rst_busy();
    test_cycle_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
